tilelink_buffer: RTL and testbench
==================================

TILELINK_BUFFER -- requirements
Module: tilelink_buffer

Interface
REQ-001 Parameters (name, default, meaning); SHALL be: AW 32 address width; DW 32 data width (8..512, power of 2); RS 4 source-ID width; ADEPTH 4 A-channel FIFO depth; DDEPTH 4 D-channel FIFO depth (each a power of 2, >=2); MAXOUT 4 in-flight limit, 1..DDEPTH.
REQ-002 Ports (name, direction, width, meaning) SHALL be: one clock and an asynchronous, active-low reset: tilelink_clock in 1 sole clock; tilelink_reset in 1 async active-low reset.
REQ-003 u_a_opcode/param/size/source/address/mask/data/corrupt in 3/3/4/RS/AW/DW/8/DW/1 upstream A payload; u_a_valid in 1; u_a_ready out 1.
REQ-004 u_d_opcode/param/size/source/denied/data/corrupt out 3/2/4/RS/1/DW/1 upstream D payload; u_d_valid out 1; u_d_ready in 1.
REQ-005 v_a_* out, same widths as u_a_*, downstream A; v_a_valid out 1; v_a_ready in 1.
REQ-006 v_d_* in, same widths as u_d_*, downstream D; v_d_valid in 1; v_d_ready out 1.
REQ-007 outstanding out clog2(MAXOUT+1) live in-flight count; tl_err out 1 sticky protocol-error flag.

Function
REQ-008 Transfer on a channel SHALL occur only in a cycle with valid and ready both high at a rising tilelink_clock edge (fire).
REQ-009 A path SHALL be a synchronous FIFO of ADEPTH entries holding the full A payload, in order; D path SHALL be one of DDEPTH entries holding the full D payload, in order.
REQ-010 u_a_ready SHALL equal (A FIFO not full) AND (outstanding < MAXOUT); it SHALL NOT depend combinationally on u_a_valid or v_a_ready.
REQ-011 v_d_ready SHALL equal (D FIFO not full), independent of v_d_valid and u_d_ready.
REQ-012 v_a_valid / u_d_valid SHALL equal FIFO not empty; payload outputs SHALL be driven from registered storage at the read pointer.
REQ-013 Latency: a beat accepted at edge N SHALL be valid on the far side after edge N (one cycle), given an empty FIFO.
REQ-014 Pointers SHALL be clog2(DEPTH)+1 bits; full when MSBs differ and remaining bits equal; empty when equal; wrap-around modulo 2*DEPTH with no lost or duplicated entry.
REQ-015 Push and pop in the same cycle SHALL leave occupancy unchanged; when full, push is impossible (ready low); when empty, pop is impossible (valid low).
REQ-016 outstanding SHALL increment on u_a fire, decrement on u_d fire, and hold when both or neither fire.
REQ-017 u_d fire while outstanding == 0 (also on v_d fire while outstanding==0 and D FIFO empty) SHALL set tl_err and leave outstanding at 0; tl_err clears only by reset.
REQ-018 Only single-beat TL-UL traffic is in scope; u_a fire with u_a_size > log2(DW/8) SHALL set tl_err and the beat SHALL still be forwarded unchanged.
REQ-019 All payload bits (including corrupt, denied, mask) SHALL pass through bit-exact; no field is interpreted except size (REQ-018).

Reset
REQ-020 While tilelink_reset is low: both FIFOs empty, outstanding=0, tl_err=0, v_a_valid=0, u_d_valid=0, u_a_ready=0, v_d_ready=0, payload outputs 0; applied asynchronously, released synchronously to tilelink_clock.
REQ-021 Reset asserted mid-transfer SHALL discard all buffered beats; first cycle after release u_a_ready=1 and v_d_ready=1.

Structure
REQ-022 Package tilelink_pkg SHALL hold the A/D opcode constants, d_param width, and the A/D payload packed-struct typedefs parameterised by width localparams.
REQ-023 One sub-module, tilelink_sync_fifo (params WIDTH, DEPTH), SHALL be instantiated twice (A, D); counter and error logic live in tilelink_buffer.

Verification
REQ-024 Reset then 4 back-to-back Get (size 2, source 0..3) with v_a_ready=1, no D -> all 4 appear on v_a in order, one per cycle after 1-cycle latency; outstanding=4; u_a_ready=0 thereafter.
REQ-025 Hold v_a_ready=0, ADEPTH=4, MAXOUT=4: 4 PutFullData accepted, 5th held (u_a_ready=0); release -> 4 emerge, data 0xA5A5_0000+i intact.
REQ-026 Simultaneous u_a fire and u_d fire at outstanding=2 -> outstanding stays 2; FIFOs wrap past index 3 over 20 random transactions with scoreboard match.
REQ-027 Inject v_d AccessAck with outstanding=0 -> tl_err=1 next cycle, outstanding stays 0, tl_err persists until reset.
REQ-028 Assert tilelink_reset with 3 beats buffered in each FIFO -> v_a_valid and u_d_valid fall immediately; after release no stale beat appears, outstanding=0.

Source files
------------

// File: rtl/tilelink_pkg.sv
// Shared TileLink-UL constants, channel payload types and width helpers
// for the A/D channel buffer.
package tilelink_pkg;

  localparam logic [2:0] PutFullData    = 3'd0;
  localparam logic [2:0] PutPartialData = 3'd1;
  localparam logic [2:0] ArithmeticData = 3'd2;
  localparam logic [2:0] LogicalData    = 3'd3;
  localparam logic [2:0] Get            = 3'd4;
  localparam logic [2:0] Intent         = 3'd5;

  localparam logic [2:0] AccessAck      = 3'd0;
  localparam logic [2:0] AccessAckData  = 3'd1;
  localparam logic [2:0] HintAck        = 3'd2;

  localparam int unsigned DParamW = 2;

  localparam int unsigned AddrW = 32;
  localparam int unsigned DataW = 32;
  localparam int unsigned SrcW  = 4;

  typedef struct packed {
    logic [2:0]         opcode;
    logic [2:0]         param;
    logic [3:0]         size;
    logic [SrcW-1:0]    source;
    logic [AddrW-1:0]   address;
    logic [DataW/8-1:0] mask;
    logic [DataW-1:0]   data;
    logic               corrupt;
  } a_chan_t;

  typedef struct packed {
    logic [2:0]         opcode;
    logic [DParamW-1:0] param;
    logic [3:0]         size;
    logic [SrcW-1:0]    source;
    logic               denied;
    logic [DataW-1:0]   data;
    logic               corrupt;
  } d_chan_t;

  // Flattened payload widths for arbitrary module parameters.
  function automatic int unsigned a_width(int unsigned aw, int unsigned dw, int unsigned rs);
    return 3 + 3 + 4 + rs + aw + dw / 8 + dw + 1;
  endfunction

  function automatic int unsigned d_width(int unsigned dw, int unsigned rs);
    return 3 + DParamW + 4 + rs + 1 + dw + 1;
  endfunction

endpackage

// File: rtl/tilelink_sync_fifo.sv
// Synchronous FIFO with extra-MSB pointers; storage is reset so the read
// port shows zeros while empty after reset.
module tilelink_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [WIDTH-1:0] wr_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] rd_data
);

  localparam int unsigned AddrW = $clog2(DEPTH);
  localparam int unsigned PtrW  = AddrW + 1;

  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             full, empty, push, pop;

  assign full  = (wr_ptr_q[PtrW-1] != rd_ptr_q[PtrW-1]) &&
                 (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign push  = wr_valid && !full;
  assign pop   = rd_ready && !empty;

  assign wr_ready = !full;
  assign rd_valid = !empty;
  assign rd_data  = mem_q[rd_ptr_q[AddrW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q[AddrW-1:0]] <= wr_data;
        wr_ptr_q <= wr_ptr_q + PtrW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
    end
  end

endmodule

// File: rtl/tilelink_buffer.sv
// TL-UL buffer: A and D channel FIFOs plus in-flight counting and a sticky
// protocol-error flag.
module tilelink_buffer import tilelink_pkg::*; #(
  parameter int unsigned AW     = 32,
  parameter int unsigned DW     = 32,
  parameter int unsigned RS     = 4,
  parameter int unsigned ADEPTH = 4,
  parameter int unsigned DDEPTH = 4,
  parameter int unsigned MAXOUT = 4
) (
  input  logic                         tilelink_clock,
  input  logic                         tilelink_reset,
  input  logic [2:0]                   u_a_opcode,
  input  logic [2:0]                   u_a_param,
  input  logic [3:0]                   u_a_size,
  input  logic [RS-1:0]                u_a_source,
  input  logic [AW-1:0]                u_a_address,
  input  logic [DW/8-1:0]              u_a_mask,
  input  logic [DW-1:0]                u_a_data,
  input  logic                         u_a_corrupt,
  input  logic                         u_a_valid,
  output logic                         u_a_ready,
  output logic [2:0]                   u_d_opcode,
  output logic [DParamW-1:0]           u_d_param,
  output logic [3:0]                   u_d_size,
  output logic [RS-1:0]                u_d_source,
  output logic                         u_d_denied,
  output logic [DW-1:0]                u_d_data,
  output logic                         u_d_corrupt,
  output logic                         u_d_valid,
  input  logic                         u_d_ready,
  output logic [2:0]                   v_a_opcode,
  output logic [2:0]                   v_a_param,
  output logic [3:0]                   v_a_size,
  output logic [RS-1:0]                v_a_source,
  output logic [AW-1:0]                v_a_address,
  output logic [DW/8-1:0]              v_a_mask,
  output logic [DW-1:0]                v_a_data,
  output logic                         v_a_corrupt,
  output logic                         v_a_valid,
  input  logic                         v_a_ready,
  input  logic [2:0]                   v_d_opcode,
  input  logic [DParamW-1:0]           v_d_param,
  input  logic [3:0]                   v_d_size,
  input  logic [RS-1:0]                v_d_source,
  input  logic                         v_d_denied,
  input  logic [DW-1:0]                v_d_data,
  input  logic                         v_d_corrupt,
  input  logic                         v_d_valid,
  output logic                         v_d_ready,
  output logic [$clog2(MAXOUT+1)-1:0] outstanding,
  output logic                         tl_err
);

  localparam int unsigned AWidth  = a_width(AW, DW, RS);
  localparam int unsigned DWidth  = d_width(DW, RS);
  localparam int unsigned OW      = $clog2(MAXOUT + 1);
  localparam int unsigned MaxSize = $clog2(DW / 8);

  logic [AWidth-1:0] a_in, a_out;
  logic [DWidth-1:0] d_in, d_out;
  logic              a_not_full, d_not_full;
  logic              u_a_fire, u_d_fire, v_d_fire;
  logic              size_bad;
  logic [OW-1:0]     outstanding_q, outstanding_d;
  logic              err_q, err_d;

  assign a_in = {u_a_opcode, u_a_param, u_a_size, u_a_source, u_a_address,
                 u_a_mask, u_a_data, u_a_corrupt};
  assign {v_a_opcode, v_a_param, v_a_size, v_a_source, v_a_address,
          v_a_mask, v_a_data, v_a_corrupt} = a_out;

  assign d_in = {v_d_opcode, v_d_param, v_d_size, v_d_source, v_d_denied,
                 v_d_data, v_d_corrupt};
  assign {u_d_opcode, u_d_param, u_d_size, u_d_source, u_d_denied,
          u_d_data, u_d_corrupt} = d_out;

  // Ready is gated by the reset input so both readies read low while held in reset.
  assign u_a_ready = tilelink_reset && a_not_full && (outstanding_q < OW'(MAXOUT));
  assign v_d_ready = tilelink_reset && d_not_full;

  assign u_a_fire = u_a_valid && u_a_ready;
  assign u_d_fire = u_d_valid && u_d_ready;
  assign v_d_fire = v_d_valid && v_d_ready;
  assign size_bad = u_a_size > 4'(MaxSize);

  tilelink_sync_fifo #(
    .WIDTH (AWidth),
    .DEPTH (ADEPTH)
  ) u_a_fifo (
    .clk      (tilelink_clock),
    .rst_n    (tilelink_reset),
    .wr_valid (u_a_fire),
    .wr_ready (a_not_full),
    .wr_data  (a_in),
    .rd_valid (v_a_valid),
    .rd_ready (v_a_ready),
    .rd_data  (a_out)
  );

  tilelink_sync_fifo #(
    .WIDTH (DWidth),
    .DEPTH (DDEPTH)
  ) u_d_fifo (
    .clk      (tilelink_clock),
    .rst_n    (tilelink_reset),
    .wr_valid (v_d_valid),
    .wr_ready (d_not_full),
    .wr_data  (d_in),
    .rd_valid (u_d_valid),
    .rd_ready (u_d_ready),
    .rd_data  (d_out)
  );

  always_comb begin
    outstanding_d = outstanding_q;
    err_d         = err_q;
    case ({u_a_fire, u_d_fire})
      2'b10:   outstanding_d = outstanding_q + OW'(1);
      2'b01:   if (outstanding_q != '0) outstanding_d = outstanding_q - OW'(1);
      default: outstanding_d = outstanding_q;
    endcase
    // A response with nothing in flight, arriving either side of the D FIFO.
    if (u_d_fire && outstanding_q == '0) err_d = 1'b1;
    if (v_d_fire && outstanding_q == '0 && !u_d_valid) err_d = 1'b1;
    if (u_a_fire && size_bad) err_d = 1'b1;
  end

  always_ff @(posedge tilelink_clock or negedge tilelink_reset) begin
    if (!tilelink_reset) begin
      outstanding_q <= '0;
      err_q         <= 1'b0;
    end else begin
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
    end
  end

  assign outstanding = outstanding_q;
  assign tl_err      = err_q;

endmodule

// File: tb/tb_tilelink_buffer.sv
// Directed and table-driven bench for tilelink_buffer at default parameters.
module tb_tilelink_buffer;

  logic        tilelink_clock = 1'b0;
  logic        tilelink_reset = 1'b0;
  logic [2:0]  u_a_opcode, u_a_param;
  logic [3:0]  u_a_size;
  logic [3:0]  u_a_source;
  logic [31:0] u_a_address;
  logic [3:0]  u_a_mask;
  logic [31:0] u_a_data;
  logic        u_a_corrupt, u_a_valid, u_a_ready;
  logic [2:0]  u_d_opcode;
  logic [1:0]  u_d_param;
  logic [3:0]  u_d_size, u_d_source;
  logic        u_d_denied;
  logic [31:0] u_d_data;
  logic        u_d_corrupt, u_d_valid, u_d_ready;
  logic [2:0]  v_a_opcode, v_a_param;
  logic [3:0]  v_a_size, v_a_source;
  logic [31:0] v_a_address;
  logic [3:0]  v_a_mask;
  logic [31:0] v_a_data;
  logic        v_a_corrupt, v_a_valid, v_a_ready;
  logic [2:0]  v_d_opcode;
  logic [1:0]  v_d_param;
  logic [3:0]  v_d_size, v_d_source;
  logic        v_d_denied;
  logic [31:0] v_d_data;
  logic        v_d_corrupt, v_d_valid, v_d_ready;
  logic [2:0]  outstanding;
  logic        tl_err;

  int checks = 0;
  int errors = 0;

  always #5 tilelink_clock = ~tilelink_clock;

  tilelink_buffer dut (
    .tilelink_clock (tilelink_clock),
    .tilelink_reset (tilelink_reset),
    .u_a_opcode     (u_a_opcode),
    .u_a_param      (u_a_param),
    .u_a_size       (u_a_size),
    .u_a_source     (u_a_source),
    .u_a_address    (u_a_address),
    .u_a_mask       (u_a_mask),
    .u_a_data       (u_a_data),
    .u_a_corrupt    (u_a_corrupt),
    .u_a_valid      (u_a_valid),
    .u_a_ready      (u_a_ready),
    .u_d_opcode     (u_d_opcode),
    .u_d_param      (u_d_param),
    .u_d_size       (u_d_size),
    .u_d_source     (u_d_source),
    .u_d_denied     (u_d_denied),
    .u_d_data       (u_d_data),
    .u_d_corrupt    (u_d_corrupt),
    .u_d_valid      (u_d_valid),
    .u_d_ready      (u_d_ready),
    .v_a_opcode     (v_a_opcode),
    .v_a_param      (v_a_param),
    .v_a_size       (v_a_size),
    .v_a_source     (v_a_source),
    .v_a_address    (v_a_address),
    .v_a_mask       (v_a_mask),
    .v_a_data       (v_a_data),
    .v_a_corrupt    (v_a_corrupt),
    .v_a_valid      (v_a_valid),
    .v_a_ready      (v_a_ready),
    .v_d_opcode     (v_d_opcode),
    .v_d_param      (v_d_param),
    .v_d_size       (v_d_size),
    .v_d_source     (v_d_source),
    .v_d_denied     (v_d_denied),
    .v_d_data       (v_d_data),
    .v_d_corrupt    (v_d_corrupt),
    .v_d_valid      (v_d_valid),
    .v_d_ready      (v_d_ready),
    .outstanding    (outstanding),
    .tl_err         (tl_err)
  );

  typedef struct {
    logic       ua_v;
    logic [3:0] ua_src;
    logic       va_r;
    logic       vd_v;
    logic [3:0] vd_src;
    logic       ud_r;
    logic       exp_va_v;
    logic [3:0] exp_va_src;
    logic       exp_ua_r;
    logic       exp_ud_v;
    logic [3:0] exp_ud_src;
    logic [2:0] exp_out;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge tilelink_clock);
    #1;
  endtask

  task automatic idle();
    u_a_opcode = 3'd4; u_a_param = '0; u_a_size = 4'd2; u_a_source = '0;
    u_a_address = 32'h1000; u_a_mask = 4'hf; u_a_data = '0; u_a_corrupt = 1'b0;
    u_a_valid = 1'b0; v_a_ready = 1'b0; u_d_ready = 1'b0;
    v_d_opcode = 3'd1; v_d_param = '0; v_d_size = 4'd2; v_d_source = '0;
    v_d_denied = 1'b0; v_d_data = '0; v_d_corrupt = 1'b0; v_d_valid = 1'b0;
  endtask

  task automatic do_reset();
    tilelink_reset = 1'b0;
    idle();
    repeat (2) @(posedge tilelink_clock);
    @(negedge tilelink_clock);
    tilelink_reset = 1'b1;
    step();
  endtask

  logic [35:0] a_q [$];
  logic [35:0] d_q [$];
  logic [3:0]  pend [$];
  logic [35:0] exp_ent;
  int model_out, a_sent, d_done;

  initial begin
    //            ua_v src va_r vd_v src ud_r | va_v src ua_r ud_v src out
    vecs[0]  = '{1'b1, 4'd0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b1, 1'b0, 4'd0, 3'd1};
    vecs[1]  = '{1'b1, 4'd1, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 4'd1, 1'b1, 1'b0, 4'd0, 3'd2};
    vecs[2]  = '{1'b1, 4'd2, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 4'd2, 1'b1, 1'b0, 4'd0, 3'd3};
    vecs[3]  = '{1'b1, 4'd3, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 4'd3, 1'b0, 1'b0, 4'd0, 3'd4};
    vecs[4]  = '{1'b1, 4'd4, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 3'd4};
    vecs[5]  = '{1'b0, 4'd0, 1'b1, 1'b1, 4'd0, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 4'd0, 3'd4};
    vecs[6]  = '{1'b0, 4'd0, 1'b1, 1'b1, 4'd1, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 4'd1, 3'd3};
    vecs[7]  = '{1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 3'd2};
    vecs[8]  = '{1'b0, 4'd0, 1'b1, 1'b1, 4'd2, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 4'd2, 3'd2};
    vecs[9]  = '{1'b1, 4'd5, 1'b1, 1'b0, 4'd0, 1'b1, 1'b1, 4'd5, 1'b1, 1'b0, 4'd0, 3'd2};
    vecs[10] = '{1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 3'd2};

    idle();
    #2;
    chk("rst_va_valid", 64'(v_a_valid), 64'd0);
    chk("rst_ua_ready", 64'(u_a_ready), 64'd0);
    chk("rst_vd_ready", 64'(v_d_ready), 64'd0);
    chk("rst_out", 64'(outstanding), 64'd0);
    do_reset();
    chk("rel_ua_ready", 64'(u_a_ready), 64'd1);
    chk("rel_vd_ready", 64'(v_d_ready), 64'd1);
    chk("rel_err", 64'(tl_err), 64'd0);

    // Back-to-back Gets, responses, then simultaneous fire at outstanding 2.
    for (int i = 0; i < 11; i++) begin
      u_a_valid = vecs[i].ua_v; u_a_source = vecs[i].ua_src; u_a_data = 32'(vecs[i].ua_src);
      v_a_ready = vecs[i].va_r;
      v_d_valid = vecs[i].vd_v; v_d_source = vecs[i].vd_src; u_d_ready = vecs[i].ud_r;
      step();
      chk($sformatf("v%0d_va_valid", i), 64'(v_a_valid), 64'(vecs[i].exp_va_v));
      chk($sformatf("v%0d_ua_ready", i), 64'(u_a_ready), 64'(vecs[i].exp_ua_r));
      chk($sformatf("v%0d_ud_valid", i), 64'(u_d_valid), 64'(vecs[i].exp_ud_v));
      chk($sformatf("v%0d_out", i), 64'(outstanding), 64'(vecs[i].exp_out));
      chk($sformatf("v%0d_err", i), 64'(tl_err), 64'd0);
      if (vecs[i].exp_va_v) chk($sformatf("v%0d_va_src", i), 64'(v_a_source), 64'(vecs[i].exp_va_src));
      if (vecs[i].exp_ud_v) chk($sformatf("v%0d_ud_src", i), 64'(u_d_source), 64'(vecs[i].exp_ud_src));
    end

    // Fill A FIFO with v_a stalled, fifth beat refused, then drain intact.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      u_a_valid = 1'b1; u_a_opcode = 3'd0; u_a_source = 4'(i);
      u_a_data = 32'hA5A5_0000 + 32'(i); u_a_mask = 4'hf;
      #1 chk("put_ua_ready", 64'(u_a_ready), 64'd1);
      step();
    end
    u_a_data = 32'hA5A5_0004; u_a_source = 4'd4;
    #1 chk("put5_ua_ready", 64'(u_a_ready), 64'd0);
    chk("put5_out", 64'(outstanding), 64'd4);
    step();
    u_a_valid = 1'b0; v_a_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 chk("put_va_valid", 64'(v_a_valid), 64'd1);
      chk("put_va_beat", 64'({v_a_opcode, v_a_source, v_a_mask, v_a_data}),
          64'({3'd0, 4'(i), 4'hf, 32'hA5A5_0000 + 32'(i)}));
      step();
    end
    chk("put_drained", 64'(v_a_valid), 64'd0);

    // Random traffic with a scoreboard; pointers wrap several times.
    do_reset();
    model_out = 0; a_sent = 0; d_done = 0;
    for (int cyc = 0; cyc < 400 && d_done < 20; cyc++) begin
      u_a_valid = (a_sent < 20) && ($urandom_range(0, 3) != 0);
      u_a_opcode = 3'd4; u_a_source = 4'(a_sent % 16); u_a_data = $urandom;
      v_a_ready = ($urandom_range(0, 3) != 0);
      v_d_valid = (pend.size() > 0) && ($urandom_range(0, 1) != 0);
      v_d_source = (pend.size() > 0) ? pend[0] : 4'd0;
      v_d_data = $urandom;
      u_d_ready = ($urandom_range(0, 3) != 0);
      #2;
      chk("rnd_out", 64'(outstanding), 64'(model_out));
      if (u_a_valid && u_a_ready) begin
        a_q.push_back({u_a_source, u_a_data}); a_sent++; model_out++;
      end
      if (v_a_valid && v_a_ready) begin
        if (a_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rnd_va_extra: got %0h expected none", {v_a_source, v_a_data});
        end else begin
          exp_ent = a_q.pop_front();
          chk("rnd_va_beat", 64'({v_a_source, v_a_data}), 64'(exp_ent));
          pend.push_back(exp_ent[35:32]);
        end
      end
      if (v_d_valid && v_d_ready) begin
        d_q.push_back({v_d_source, v_d_data});
        void'(pend.pop_front());
      end
      if (u_d_valid && u_d_ready) begin
        if (d_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rnd_ud_extra: got %0h expected none", {u_d_source, u_d_data});
        end else begin
          chk("rnd_ud_beat", 64'({u_d_source, u_d_data}), 64'(d_q.pop_front()));
          model_out--; d_done++;
        end
      end
      step();
    end
    chk("rnd_done", 64'(d_done), 64'd20);
    chk("rnd_err", 64'(tl_err), 64'd0);

    // Unsolicited response sets a sticky error.
    do_reset();
    v_d_valid = 1'b1; v_d_opcode = 3'd0; v_d_source = 4'd0;
    step();
    chk("unsol_err", 64'(tl_err), 64'd1);
    chk("unsol_out", 64'(outstanding), 64'd0);
    v_d_valid = 1'b0; u_d_ready = 1'b1;
    step();
    chk("unsol_out2", 64'(outstanding), 64'd0);
    repeat (3) step();
    chk("unsol_sticky", 64'(tl_err), 64'd1);

    // Oversized request flags an error yet is forwarded unchanged.
    do_reset();
    u_a_valid = 1'b1; u_a_opcode = 3'd4; u_a_size = 4'd3; u_a_source = 4'd7;
    step();
    u_a_valid = 1'b0;
    chk("size_err", 64'(tl_err), 64'd1);
    chk("size_fwd", 64'({v_a_valid, v_a_size, v_a_source}), 64'({1'b1, 4'd3, 4'd7}));
    chk("size_out", 64'(outstanding), 64'd1);

    // Reset with beats buffered in both FIFOs.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      u_a_valid = 1'b1; u_a_source = 4'(i); u_a_data = 32'hC0DE_0000 + 32'(i);
      step();
    end
    u_a_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      v_d_valid = 1'b1; v_d_source = 4'(i); v_d_data = 32'hD00D_0000 + 32'(i);
      step();
    end
    v_d_valid = 1'b0;
    chk("pre_rst_va", 64'(v_a_valid), 64'd1);
    chk("pre_rst_ud", 64'(u_d_valid), 64'd1);
    chk("pre_rst_out", 64'(outstanding), 64'd3);
    #2 tilelink_reset = 1'b0;
    #1;
    chk("mid_rst_valids", 64'({v_a_valid, u_d_valid, u_a_ready, v_d_ready}), 64'd0);
    chk("mid_rst_payload", 64'({v_a_data, u_d_data}), 64'd0);
    chk("mid_rst_out", 64'(outstanding), 64'd0);
    v_a_ready = 1'b1; u_d_ready = 1'b1;
    @(negedge tilelink_clock);
    tilelink_reset = 1'b1;
    #1;
    chk("post_rst_ready", 64'({u_a_ready, v_d_ready}), 64'b11);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_stale", 64'({v_a_valid, u_d_valid, tl_err}), 64'd0);
      chk("post_rst_out", 64'(outstanding), 64'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
